irq_ctrl: RTL and testbench

- Interrupt controller that requests service from the multi-cycle CPU control unit: it drives INT_irq and receives INTA_irq and EOI.
- Latches up to N peripheral interrupt sources and applies a per-source mask.
- Selects the highest-priority request and presents its ID and handler vector to the datapath.
- Tracks in-service state until the handler returns (MOVS PC path), so at most one interrupt is outstanding.

---
 rtl/irq_ctrl_if.sv | 22 ++
 rtl/irq_ctrl.sv | 122 ++++++++++++
 tb/tb_irq_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_if.sv
// CPU-side handshake between the interrupt controller and the multi-cycle control unit.
// master = interrupt controller, slave = CPU control unit.
interface irq_ctrl_if #(
   parameter int ID_W = 3
);
   logic            INT_irq;
   logic            INTA_irq;
   logic            EOI;
   logic            in_service;
   logic [ID_W-1:0] irq_id;
   logic [31:0]     irq_vector;

   modport master (
      output INT_irq, irq_id, irq_vector, in_service,
      input  INTA_irq, EOI
   );

   modport slave (
      input  INT_irq, irq_id, irq_vector, in_service,
      output INTA_irq, EOI
   );
endinterface

// File: rtl/irq_ctrl.sv
// Fixed-priority interrupt controller: latches edge/level sources, requests the CPU,
// and holds one interrupt in service until the handler signals EOI.
module irq_ctrl #(
   parameter int          N        = 8,
   parameter int          ID_W     = 3,
   parameter logic [31:0] VEC_BASE = 32'h0000_0018
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] irq_src,
   input  logic [N-1:0] irq_mask,
   input  logic [N-1:0] edge_sel,
   output logic [N-1:0] pending,
   irq_ctrl_if.master   cpu
);
   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    pending_q, pending_d;
   logic [N-1:0]    src_q;
   logic [N-1:0]    active;
   logic [N-1:0]    clr;
   logic            inta_q;
   logic            ack;
   logic            take_ack;
   logic            int_irq_q, int_irq_d;
   logic            in_service_q, in_service_d;
   logic [ID_W-1:0] irq_id_q, irq_id_d;
   logic [ID_W-1:0] sel;

   assign active   = pending_q & ~irq_mask;
   assign ack      = cpu.INTA_irq & ~inta_q;
   assign take_ack = (state_q == REQ) && ack;

   // Lowest index wins: scan downward so the last hit is the smallest index.
   always_comb begin
      sel = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (active[i]) sel = ID_W'(i);
      end
   end

   // Edge sources: a new rising edge beats a same-cycle acknowledge clear.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_pend
         assign clr[gi]       = take_ack && (irq_id_q == ID_W'(gi));
         assign pending_d[gi] = edge_sel[gi]
                              ? ((pending_q[gi] & ~clr[gi]) | (irq_src[gi] & ~src_q[gi]))
                              : irq_src[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         pending_q    <= '0;
         src_q        <= '0;
         inta_q       <= 1'b0;
         int_irq_q    <= 1'b0;
         in_service_q <= 1'b0;
         irq_id_q     <= '0;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         src_q        <= irq_src;
         inta_q       <= cpu.INTA_irq;
         int_irq_q    <= int_irq_d;
         in_service_q <= in_service_d;
         irq_id_q     <= irq_id_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|active) state_d = REQ;
         REQ: begin
            if (ack)           state_d = SERVICE;
            else if (~|active) state_d = IDLE;
         end
         SERVICE: if (cpu.EOI) state_d = IDLE;
         default:              state_d = IDLE;
      endcase
   end

   always_comb begin
      int_irq_d    = int_irq_q;
      in_service_d = in_service_q;
      irq_id_d     = irq_id_q;
      case (state_q)
         IDLE: begin
            int_irq_d = |active;
            if (|active) irq_id_d = sel;
         end
         REQ: begin
            if (ack) begin
               int_irq_d    = 1'b0;
               in_service_d = 1'b1;
            end else if (~|active) begin
               int_irq_d = 1'b0;
            end else begin
               int_irq_d = 1'b1;
               irq_id_d  = sel;
            end
         end
         SERVICE: begin
            int_irq_d = 1'b0;
            if (cpu.EOI) in_service_d = 1'b0;
         end
         default: begin
            int_irq_d    = 1'b0;
            in_service_d = 1'b0;
         end
      endcase
   end

   assign pending        = pending_q;
   assign cpu.INT_irq    = int_irq_q;
   assign cpu.in_service = in_service_q;
   assign cpu.irq_id     = irq_id_q;
   assign cpu.irq_vector = VEC_BASE + (32'(irq_id_q) << 2);
endmodule

// File: tb/tb_irq_ctrl.sv
// Directed-vector bench for irq_ctrl: each phase drives inputs, advances whole clocks,
// and compares registered outputs 1 time unit after the rising edge.
module tb_irq_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] irq_src;
   logic [7:0] irq_mask;
   logic [7:0] edge_sel;
   logic [7:0] pending;

   int n_checks = 0;
   int n_errors = 0;

   irq_ctrl_if #(.ID_W(3)) cpu_if ();

   irq_ctrl #(
      .N        (8),
      .ID_W     (3),
      .VEC_BASE (32'h0000_0018)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .irq_src  (irq_src),
      .irq_mask (irq_mask),
      .edge_sel (edge_sel),
      .pending  (pending),
      .cpu      (cpu_if)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst             = 1'b0;
      irq_src         = 8'hFF;
      irq_mask        = 8'h00;
      edge_sel        = 8'h00;
      cpu_if.INTA_irq = 1'b0;
      cpu_if.EOI      = 1'b0;

      // Reset with all level sources high
      step(2);
      check("rst_int", 32'(cpu_if.INT_irq), 32'd0);
      check("rst_pend", 32'(pending), 32'h00);
      check("rst_insvc", 32'(cpu_if.in_service), 32'd0);
      check("rst_id", 32'(cpu_if.irq_id), 32'd0);
      rst = 1'b1;
      step(1);
      check("rel_pend", 32'(pending), 32'hFF);
      check("rel_int0", 32'(cpu_if.INT_irq), 32'd0);
      step(1);
      check("rel_int1", 32'(cpu_if.INT_irq), 32'd1);
      check("rel_id", 32'(cpu_if.irq_id), 32'd0);
      rst = 1'b0;
      irq_src = 8'h00;
      step(1);
      check("midrst_int", 32'(cpu_if.INT_irq), 32'd0);
      check("midrst_pend", 32'(pending), 32'h00);
      rst = 1'b1;
      step(1);
      $display("phase reset done");

      // Single edge request on source 5
      edge_sel = 8'hFF;
      irq_src  = 8'h20;
      step(1);
      check("e5_pend", 32'(pending), 32'h20);
      check("e5_int0", 32'(cpu_if.INT_irq), 32'd0);
      irq_src = 8'h00;
      step(1);
      check("e5_int", 32'(cpu_if.INT_irq), 32'd1);
      check("e5_id", 32'(cpu_if.irq_id), 32'd5);
      check("e5_vec", cpu_if.irq_vector, 32'h0000_002C);
      cpu_if.INTA_irq = 1'b1;
      step(1);
      check("e5_ack_int", 32'(cpu_if.INT_irq), 32'd0);
      check("e5_ack_svc", 32'(cpu_if.in_service), 32'd1);
      check("e5_ack_pend", 32'(pending), 32'h00);
      cpu_if.INTA_irq = 1'b0;
      cpu_if.EOI      = 1'b1;
      step(1);
      cpu_if.EOI = 1'b0;
      check("e5_eoi_svc", 32'(cpu_if.in_service), 32'd0);
      step(1);
      check("e5_idle_int", 32'(cpu_if.INT_irq), 32'd0);
      $display("phase edge request done");

      // Priority and preemption: 6 then 2
      irq_src = 8'h40;
      step(1);
      irq_src = 8'h04;
      step(1);
      check("pr_id6", 32'(cpu_if.irq_id), 32'd6);
      check("pr_vec6", cpu_if.irq_vector, 32'h0000_0030);
      irq_src = 8'h00;
      step(1);
      check("pr_id2", 32'(cpu_if.irq_id), 32'd2);
      check("pr_int", 32'(cpu_if.INT_irq), 32'd1);
      cpu_if.INTA_irq = 1'b1;
      step(1);
      check("pr_ack_id", 32'(cpu_if.irq_id), 32'd2);
      check("pr_ack_pend", 32'(pending), 32'h40);
      cpu_if.INTA_irq = 1'b0;
      cpu_if.EOI      = 1'b1;
      step(1);
      cpu_if.EOI = 1'b0;
      check("pr_eoi_int", 32'(cpu_if.INT_irq), 32'd0);
      step(1);
      check("pr_re_int", 32'(cpu_if.INT_irq), 32'd1);
      check("pr_re_id", 32'(cpu_if.irq_id), 32'd6);
      cpu_if.INTA_irq = 1'b1;
      step(1);
      cpu_if.INTA_irq = 1'b0;
      cpu_if.EOI      = 1'b1;
      step(1);
      cpu_if.EOI = 1'b0;
      step(1);
      $display("phase priority done");

      // Level drop before ack, then a masked source
      edge_sel = 8'h00;
      irq_src  = 8'h08;
      step(2);
      check("lv_int", 32'(cpu_if.INT_irq), 32'd1);
      check("lv_id", 32'(cpu_if.irq_id), 32'd3);
      irq_src = 8'h00;
      step(1);
      check("lv_pend", 32'(pending), 32'h00);
      step(1);
      check("lv_drop_int", 32'(cpu_if.INT_irq), 32'd0);
      check("lv_drop_id", 32'(cpu_if.irq_id), 32'd3);
      irq_mask = 8'h02;
      irq_src  = 8'h02;
      step(3);
      check("mk_pend", 32'(pending), 32'h02);
      check("mk_int", 32'(cpu_if.INT_irq), 32'd0);
      irq_src = 8'h00;
      step(1);
      irq_mask = 8'h00;
      step(1);
      $display("phase level/mask done");

      // Held INTA across EOI, stray EOI and INTA in IDLE
      edge_sel = 8'hFF;
      irq_src  = 8'h01;
      step(1);
      irq_src = 8'h00;
      step(1);
      cpu_if.INTA_irq = 1'b1;
      step(1);
      check("hi_svc", 32'(cpu_if.in_service), 32'd1);
      irq_src = 8'h02;
      step(1);
      irq_src    = 8'h00;
      cpu_if.EOI = 1'b1;
      step(1);
      cpu_if.EOI = 1'b0;
      check("hi_eoi_svc", 32'(cpu_if.in_service), 32'd0);
      step(1);
      check("hi_req_id", 32'(cpu_if.irq_id), 32'd1);
      step(2);
      check("hi_held_int", 32'(cpu_if.INT_irq), 32'd1);
      check("hi_held_svc", 32'(cpu_if.in_service), 32'd0);
      cpu_if.INTA_irq = 1'b0;
      step(1);
      cpu_if.INTA_irq = 1'b1;
      step(1);
      check("hi_ack_int", 32'(cpu_if.INT_irq), 32'd0);
      check("hi_ack_svc", 32'(cpu_if.in_service), 32'd1);
      check("hi_ack_pend", 32'(pending), 32'h00);
      cpu_if.INTA_irq = 1'b0;
      cpu_if.EOI      = 1'b1;
      step(1);
      cpu_if.EOI = 1'b0;
      step(1);
      cpu_if.EOI = 1'b1;
      step(1);
      cpu_if.EOI = 1'b0;
      check("st_eoi_svc", 32'(cpu_if.in_service), 32'd0);
      check("st_eoi_id", 32'(cpu_if.irq_id), 32'd1);
      cpu_if.INTA_irq = 1'b1;
      step(1);
      cpu_if.INTA_irq = 1'b0;
      check("st_inta_svc", 32'(cpu_if.in_service), 32'd0);
      check("st_inta_int", 32'(cpu_if.INT_irq), 32'd0);
      step(1);
      $display("phase held/stray done");

      // New edge on source 4 in its own ack cycle
      irq_src = 8'h10;
      step(1);
      irq_src = 8'h00;
      step(1);
      check("sm_id", 32'(cpu_if.irq_id), 32'd4);
      cpu_if.INTA_irq = 1'b1;
      irq_src         = 8'h10;
      step(1);
      check("sm_pend", 32'(pending), 32'h10);
      check("sm_svc", 32'(cpu_if.in_service), 32'd1);
      irq_src         = 8'h00;
      cpu_if.INTA_irq = 1'b0;
      cpu_if.EOI      = 1'b1;
      step(1);
      cpu_if.EOI = 1'b0;
      step(1);
      check("sm_re_int", 32'(cpu_if.INT_irq), 32'd1);
      check("sm_re_id", 32'(cpu_if.irq_id), 32'd4);
      $display("phase simultaneous done");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
